// File: rtl/seq_detect_pkg.sv
// Shared constants and state encoding for the 1101 Mealy detector.
package seq_detect_pkg;

  localparam logic [3:0] PATTERN = 4'b1101;
  localparam int         PAT_LEN = 4;
  localparam int         CNT_W   = 16;

  // State name = length of the pattern prefix matched so far.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; pins at all-ones instead of wrapping.
module seq_match_counter
  import seq_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/seq_detect_mealy.sv
// Overlapping Mealy detector for 1101; y is combinational on the current din.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detect_mealy
  import seq_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_DET_COUNT_EN
  output logic [CNT_W-1:0] match_count,
`endif
  input  logic             din,
  output logic             y
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S0;
    y       = 1'b0;
    case (state_q)
      S0: state_d = din ? S1 : S0;
      S1: state_d = din ? S2 : S0;
      // Extra 1s keep the "11" suffix alive.
      S2: state_d = din ? S2 : S3;
      S3: begin
        // A match reuses its trailing 1 as the start of the next prefix.
        state_d = din ? S1 : S0;
        y       = din;
      end
      default: state_d = S0;
    endcase
  end

`ifdef SEQ_DET_COUNT_EN
  seq_match_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (y),
    .count (match_count)
  );
`endif

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Scoreboard bench for seq_detect_mealy; expected y comes from a bit-history model.
module tb_seq_detect_mealy;

  logic clk, rst, din, y;
`ifdef SEQ_DET_COUNT_EN
  logic [15:0] match_count;
`endif

  int errs   = 0;
  int checks = 0;

  bit       exp_q[$];
  logic [2:0] hist;
  int       nbits;

  seq_detect_mealy dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SEQ_DET_COUNT_EN
    .match_count (match_count),
`endif
    .din         (din),
    .y           (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    hist  = 3'b000;
    nbits = 0;
  endtask

  // Called just after a posedge: drive b, predict y, check at negedge,
  // let the next posedge consume b, then advance the model.
  task automatic send_bit(input string tag, input bit b);
    bit e;
    bit got;
    din = b;
    exp_q.push_back((nbits >= 3) && ({hist, b} == 4'b1101));
    @(negedge clk);
    got = y;
    e   = exp_q.pop_front();
    chk(tag, {31'd0, got}, {31'd0, e});
    @(posedge clk);
    #1;
    hist  = {hist[1:0], b};
    nbits = nbits + 1;
  endtask

  task automatic send_seq(input string tag, input bit bits[]);
    foreach (bits[i]) send_bit($sformatf("%s[%0d]", tag, i), bits[i]);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    bit s1[] = '{1,1,0,1};
    bit s2[] = '{1,1,0,1,1,0,1,1,1,1,0,1};
    bit s3[] = '{1,0,1,0,1,1,1,0,0,1};
    bit s4a[] = '{1,1,0};
    bit s4b[] = '{1,1,1,0,1};
    bit s5[] = '{1,0,1};

    rst = 1'b0;
    din = 1'b1;
    model_clear();

    // T1: reset held with din=1
    repeat (2) begin
      @(negedge clk);
      chk("rst_y", {31'd0, y}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("rst_y_din1", {31'd0, y}, 32'd0);
    rst = 1'b1;
    send_seq("t1", s1);

    // T2: overlap and repeated ones
    reset_pulse();
    send_seq("t2", s2);
`ifdef SEQ_DET_COUNT_EN
    chk("t2_count", {16'd0, match_count}, 32'd3);
`endif

    // T3: near-misses
    send_seq("t3", s3);

    // T4: reset mid-pattern discards the partial 110
    reset_pulse();
    send_seq("t4a", s4a);
    rst = 1'b0;
    din = 1'b1;
    #1;
    chk("t4_rst_y", {31'd0, y}, 32'd0);
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    chk("t4_post_y", {31'd0, y}, 32'd0);
    send_seq("t4b", s4b);

    // T5: y follows din combinationally inside one cycle in S3
    reset_pulse();
    send_seq("t5a", s4a);
    din = 1'b0; #1; chk("t5_d0", {31'd0, y}, 32'd0);
    din = 1'b1; #1; chk("t5_d1", {31'd0, y}, 32'd1);
    din = 1'b0; #1; chk("t5_d0b", {31'd0, y}, 32'd0);
    @(posedge clk);
    #1;
    hist  = {hist[1:0], 1'b0};
    nbits = nbits + 1;
    send_seq("t5b", s5);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
